// File: rtl/instr_fifo_pkg.sv
// Shared types and field constants for the ALU command queue.
// Command word layout is {A[5:0], B[5:0], instruct[2:0]}.
package instr_fifo_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SWITCH = 2'd1,
        S_EXEC   = 2'd2
    } fifo_state_t;

    localparam int DW     = 15;
    localparam int A_MSB  = 14;
    localparam int A_LSB  = 9;
    localparam int B_MSB  = 8;
    localparam int B_LSB  = 3;
    localparam int OP_MSB = 2;
    localparam int OP_LSB = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;

    function automatic logic [DW-1:0] pack_cmd(
        input logic [A_MSB-A_LSB:0]   a,
        input logic [B_MSB-B_LSB:0]   b,
        input logic [OP_MSB-OP_LSB:0] op
    );
        return {a, b, op};
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Command storage: synchronous write, combinational read.
// Contents are deliberately left unreset.
module fifo_regfile #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 15
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    import instr_fifo_pkg::*;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fifo_ctrl.sv
// Command queue: load commands in LOAD mode, replay them in EXEC mode.
// data_out is registered and holds between pops.
module instr_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 15
) (
    input  logic          clock,
    input  logic          rstsync,
    input  logic          mode,
    input  logic          step,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          ovf_err,
    output logic          udf_err
);
    import instr_fifo_pkg::*;

    localparam int CW = AW + 1;

    fifo_state_t   state;
    logic          push_req;
    logic          pop_req;
    logic          do_push;
    logic          do_pop;
    logic [DW-1:0] rd_word;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A step only counts once the state agrees with the mode level
    assign push_req = step && (state == S_LOAD) && !mode;
    assign pop_req  = step && (state == S_EXEC) && mode;
    assign do_push  = push_req && !full;
    assign do_pop   = pop_req && !empty;

    fifo_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_regfile (
        .clock (clock),
        .we    (do_push),
        .waddr (wr_addr),
        .wdata (data_in),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    always_ff @(posedge clock or negedge rstsync) begin
        if (!rstsync) begin
            state      <= S_LOAD;
            wr_addr    <= '0;
            rd_addr    <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (mode) begin
                        state <= S_SWITCH;
                    end
                end
                S_EXEC: begin
                    if (!mode) begin
                        state <= S_SWITCH;
                    end
                end
                S_SWITCH: begin
                    state      <= mode ? S_EXEC : S_LOAD;
                    data_valid <= 1'b0;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase

            if (do_push) begin
                wr_addr <= wr_addr + AW'(1);
                count   <= count + CW'(1);
            end
            if (push_req && full) begin
                ovf_err <= 1'b1;
            end

            if (do_pop) begin
                data_out   <= rd_word;
                data_valid <= 1'b1;
                rd_addr    <= rd_addr + AW'(1);
                count      <= count - CW'(1);
            end
            if (pop_req && empty) begin
                udf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fifo_ctrl.sv
// Bench for instr_fifo_ctrl: directed scenarios plus random traffic
// checked against a queue-based model of the command buffer.
module tb_instr_fifo_ctrl;
    import instr_fifo_pkg::*;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        rstsync;
    logic        mode;
    logic        step;
    logic [14:0] data_in;
    logic [14:0] data_out;
    logic        data_valid;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic [2:0]  wr_addr;
    logic [2:0]  rd_addr;
    logic        ovf_err;
    logic        udf_err;

    int checks = 0;
    int errors = 0;

    logic [14:0] q[$];
    logic [14:0] e_out;
    logic        e_valid;
    logic        e_ovf;
    logic        e_udf;
    int          n_push;
    int          n_pop;
    logic        cur_mode;

    instr_fifo_ctrl u_dut (
        .clock      (clock),
        .rstsync    (rstsync),
        .mode       (mode),
        .step       (step),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".data_out"}, 32'(data_out), 32'(e_out));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(e_valid));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(n_push % DEPTH));
        chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(n_pop % DEPTH));
        chk({tag, ".ovf_err"}, 32'(ovf_err), 32'(e_ovf));
        chk({tag, ".udf_err"}, 32'(udf_err), 32'(e_udf));
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        e_out    = '0;
        e_valid  = 1'b0;
        e_ovf    = 1'b0;
        e_udf    = 1'b0;
        n_push   = 0;
        n_pop    = 0;
        cur_mode = 1'b0;
    endtask

    task automatic do_reset();
        mode    = 1'b0;
        step    = 1'b0;
        rstsync = 1'b0;
        model_reset();
        cycle();
        rstsync = 1'b1;
        cycle();
    endtask

    task automatic push(input logic [14:0] d);
        data_in = d;
        step    = 1'b1;
        cycle();
        step    = 1'b0;
        if (q.size() < DEPTH) begin
            q.push_back(d);
            n_push++;
        end else begin
            e_ovf = 1'b1;
        end
    endtask

    task automatic pop();
        step = 1'b1;
        cycle();
        step = 1'b0;
        if (q.size() > 0) begin
            e_out   = q.pop_front();
            e_valid = 1'b1;
            n_pop++;
        end else begin
            e_udf = 1'b1;
        end
    endtask

    // Mode change: two ignored cycles, step optionally held throughout
    task automatic set_mode(input logic m, input logic with_step);
        mode    = m;
        step    = with_step;
        data_in = 15'h5555;
        cycle();
        check_all("switch1");
        cycle();
        step     = 1'b0;
        e_valid  = 1'b0;
        cur_mode = m;
    endtask

    initial begin
        rstsync = 1'b0;
        mode    = 1'b0;
        step    = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        rstsync = 1'b1;
        cycle();

        // Basic load and replay
        push(15'h1208);
        push(15'h0A41);
        push(15'h7FFE);
        check_all("t1.load");
        chk("t1.count3", 32'(count), 32'd3);
        set_mode(1'b1, 1'b0);
        pop();
        chk("t1.pop0", 32'(data_out), 32'h1208);
        pop();
        chk("t1.pop1", 32'(data_out), 32'h0A41);
        pop();
        chk("t1.pop2", 32'(data_out), 32'h7FFE);
        check_all("t1.done");
        chk("t1.empty", 32'(empty), 32'd1);

        // Fill and overflow
        set_mode(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) push(15'(i));
        chk("t2.full", 32'(full), 32'd1);
        chk("t2.count8", 32'(count), 32'd8);
        push(15'h7777);
        chk("t2.ovf", 32'(ovf_err), 32'd1);
        chk("t2.wr_addr", 32'(wr_addr), 32'(3 + 8) % 8);
        check_all("t2.ovf");
        set_mode(1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            pop();
            chk("t2.drain", 32'(data_out), 32'(i));
        end
        check_all("t2.done");

        // Underflow with a live command on the output
        set_mode(1'b0, 1'b0);
        push(15'h0A41);
        set_mode(1'b1, 1'b0);
        pop();
        pop();
        chk("t4.data_out", 32'(data_out), 32'h0A41);
        chk("t4.valid", 32'(data_valid), 32'd1);
        chk("t4.udf", 32'(udf_err), 32'd1);
        check_all("t4");

        // Wrap-around from a clean reset
        do_reset();
        check_all("t3.reset");
        for (int i = 0; i < 6; i++) push(15'(16'h100 + i));
        set_mode(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) pop();
        set_mode(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) push(15'(16'h200 + i));
        set_mode(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pop();
            chk("t3.order", 32'(data_out), 32'(16'h200 + i));
        end
        chk("t3.wr_addr", 32'(wr_addr), 32'd3);
        chk("t3.rd_addr", 32'(rd_addr), 32'd3);
        check_all("t3.done");

        // Step during mode change is ignored
        set_mode(1'b0, 1'b1);
        push(15'h0123);
        set_mode(1'b1, 1'b1);
        chk("t5.count", 32'(count), 32'd1);
        chk("t5.valid", 32'(data_valid), 32'd0);
        check_all("t5");

        // Asynchronous reset mid-operation
        set_mode(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(15'(16'h300 + i));
        set_mode(1'b1, 1'b0);
        pop();
        pop();
        check_all("t6.pre");
        mode = 1'b0;
        #2;
        rstsync = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        cycle();
        rstsync = 1'b1;
        cycle();
        push(15'h0777);
        check_all("t6.resume");

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_mode(~cur_mode, 1'($urandom_range(0, 1)));
            end else if (cur_mode == 1'b0) begin
                push(15'($urandom));
            end else begin
                pop();
            end
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fifo_ctrl.md
Name: instr_fifo_ctrl

Overview:
Upstream command-queue stage for the ALU datapath. It buffers up to eight operator-entered commands, each packed as {A[5:0], B[5:0], instruct[2:0]}, and later replays them one per step. It replaces the split read/write FSM and memory pair with a single self-checking block. It produces the registered 15-bit word that the ALU decode and display stage consumes.

Parameters:
DEPTH, 8, number of queue entries; must be a power of two.
AW, 3, pointer width, equal to log2(DEPTH).
DW, 15, command word width.

Ports:
clock  input  1  system clock
rstsync  input  1  reset, asynchronous, active-low
mode  input  1  0 = LOAD (enqueue), 1 = EXEC (dequeue); level, already synchronous to clock
step  input  1  single-cycle pulse from the button synchronizer
data_in  input  DW  {A, B, instruct} from the switches
data_out  output  DW  current command presented to the ALU; registered
data_valid  output  1  data_out holds a dequeued command
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  occupancy, 0..DEPTH
wr_addr  output  AW  write pointer, for debug LEDs
rd_addr  output  AW  read pointer, for debug LEDs
ovf_err  output  1  sticky: push attempted while full
udf_err  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (rstsync low, asynchronous) forces:
  - wr_addr = 0, rd_addr = 0, count = 0
  - data_out = 0, data_valid = 0, ovf_err = 0, udf_err = 0
  - FSM state = S_LOAD
  - Storage array is not reset.
- FSM states:
  - S_LOAD: accepts pushes.
  - S_EXEC: accepts pops.
  - S_SWITCH: one-cycle guard state.
- FSM transitions:
  - S_LOAD -> S_SWITCH when mode == 1.
  - S_EXEC -> S_SWITCH when mode == 0.
  - S_SWITCH -> S_EXEC if mode == 1, else -> S_LOAD.
- step is ignored in S_SWITCH and in the first cycle mode differs from the state's mode. Mode change wins over a simultaneous step.
- Entering S_EXEC from S_SWITCH clears data_valid to 0. Entering S_LOAD also clears data_valid to 0.
- Push (S_LOAD, step = 1, !full):
  - mem[wr_addr] <= data_in
  - wr_addr increments modulo DEPTH; wraps 7 -> 0
  - count increments
  - All three updates occur on the same clock edge.
- Pop (S_EXEC, step = 1, !empty):
  - data_out <= mem[rd_addr]; data_valid <= 1
  - rd_addr increments modulo DEPTH; count decrements
  - Latency: data_out is valid the first edge after the step pulse edge.
- Push while full: data dropped, pointers and count unchanged, ovf_err <= 1.
- Pop while empty: data_out and data_valid hold their previous values, udf_err <= 1.
- Error flags are sticky until rstsync.
- Push and pop can never coincide, since they are mode-exclusive. count therefore changes by at most 1 per cycle.
- full and empty are combinational decodes of count. Both are never 1 at the same time.
- Reset asserted mid-operation: every queued entry is discarded immediately (asynchronous). Operation resumes in S_LOAD on the first edge after deassertion.
- data_out is stable between pops. The downstream ALU may sample it at any time while data_valid = 1.

Decomposition:
- Package instr_fifo_pkg contains:
  - typedef enum {S_LOAD, S_SWITCH, S_EXEC} fifo_state_t
  - constants DW = 15, A_MSB = 14, A_LSB = 9, B_MSB = 8, B_LSB = 3, OP_MSB = 2, OP_LSB = 0
  - opcode constants OP_ADD = 3'b000, OP_SUB = 3'b001, OP_EQ = 3'b100, OP_GT = 3'b101, OP_LT = 3'b110
- One sub-module: fifo_regfile.
  - DEPTH x DW register array with synchronous write (we, waddr, wdata) and combinational read (raddr, rdata).
  - No reset on the array.
- The FSM, pointers, count and error flags live in instr_fifo_ctrl.

Test Plan:
1. Reset, then LOAD: push 3 words 15'h1208, 15'h0A41, 15'h7FFE, switch mode to 1, pop 3 times -> data_out returns 15'h1208, 15'h0A41, 15'h7FFE in order, each one cycle after its step. count goes 3 -> 0, empty = 1, udf_err = 0.
2. Fill: push 8 words (0x0001..0x0008) -> full = 1, count = 8. A ninth push of 0x7777 -> ovf_err = 1, count = 8, wr_addr = 0. Draining yields 0x0001..0x0008 and never 0x7777.
3. Wrap-around: push 6, pop 6, push 5, pop 5 -> wr_addr = rd_addr = 3. Data order is preserved across the 7 -> 0 boundary.
4. Pop while empty in EXEC with data_out = 0x0A41 -> data_out stays 0x0A41, data_valid stays 1, udf_err = 1, count = 0.
5. step asserted in the same cycle mode toggles 0 -> 1, and again during S_SWITCH -> no push and no pop, count unchanged. data_valid = 0 on entry to S_EXEC.
6. Push 4 words, pop 2, assert rstsync low asynchronously between clock edges -> outputs clear immediately: count = 0, empty = 1, data_valid = 0, data_out = 0, errors = 0. After release the FSM is in S_LOAD.
